// File: rtl/vector_permute_pkg.sv
// Shared types and helpers for the vector permute unit: op encoding,
// sign-flip helper and the parameter sanity check used at elaboration.
package vector_permute_pkg;

    typedef enum logic [2:0] {
        SKEW      = 3'b000,
        TRANSPOSE = 3'b001,
        NEGATE    = 3'b010,
        BROADCAST = 3'b011,
        PERMUTE   = 3'b100,
        LOAD_PERM = 3'b101,
        PASS      = 3'b110,
        RSVD      = 3'b111
    } funct_e;

    localparam int NEG_MAX_W = 64;

    // Flips the sign bit of a lane up to NEG_MAX_W bits wide; width picks the sign position.
    function automatic logic [NEG_MAX_W-1:0] neg(input logic [NEG_MAX_W-1:0] x,
                                                 input int unsigned width);
        logic [NEG_MAX_W-1:0] r;
        r = x;
        r[width-1] = ~r[width-1];
        return r;
    endfunction

    function automatic bit params_ok(input int lanes, input int dim, input int width);
        return (lanes >= 9) && (dim >= 1) && (dim * dim <= lanes) &&
               (width >= 1) && (width <= NEG_MAX_W);
    endfunction

endpackage

// File: rtl/vector_permute_xbar.sv
// Combinational lane crossbar: computes the result vector for every op
// from the input lanes, the broadcast select and the permute table.
module vector_permute_xbar
    import vector_permute_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int VECTOR_LANES = 16,
    parameter int MAT_DIM      = 3,
    localparam int IDX_W       = $clog2(VECTOR_LANES)
) (
    input  logic [2:0]                         funct,
    input  logic [IDX_W-1:0]                   lane_sel,
    input  logic [VECTOR_LANES*DATA_WIDTH-1:0] vec_in,
    input  logic [VECTOR_LANES*IDX_W-1:0]      perm,
    output logic [VECTOR_LANES*DATA_WIDTH-1:0] next_vec
);

    logic [DATA_WIDTH-1:0] in_l  [VECTOR_LANES];
    logic [DATA_WIDTH-1:0] out_l [VECTOR_LANES];
    logic [IDX_W-1:0]      idx;

    function automatic logic [DATA_WIDTH-1:0] neg_l(input logic [DATA_WIDTH-1:0] x);
        logic [NEG_MAX_W-1:0] w;
        w = neg(NEG_MAX_W'(x), DATA_WIDTH);
        return w[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < VECTOR_LANES; i++) begin
            in_l[i] = vec_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        idx = '0;
        for (int i = 0; i < VECTOR_LANES; i++) begin
            out_l[i] = '0;
        end
        case (funct_e'(funct))
            // Cross-product skew matrix of (v0, v1, v2), row-major in lanes 0..8.
            SKEW: begin
                out_l[1] = in_l[2];
                out_l[2] = neg_l(in_l[1]);
                out_l[3] = neg_l(in_l[2]);
                out_l[5] = in_l[0];
                out_l[6] = in_l[1];
                out_l[7] = neg_l(in_l[0]);
            end
            TRANSPOSE: begin
                for (int r = 0; r < MAT_DIM; r++) begin
                    for (int c = 0; c < MAT_DIM; c++) begin
                        out_l[MAT_DIM*r + c] = in_l[MAT_DIM*c + r];
                    end
                end
            end
            NEGATE: begin
                for (int i = 0; i < VECTOR_LANES; i++) begin
                    out_l[i] = neg_l(in_l[i]);
                end
            end
            BROADCAST: begin
                if (int'(lane_sel) < VECTOR_LANES) begin
                    for (int i = 0; i < VECTOR_LANES; i++) begin
                        out_l[i] = in_l[lane_sel];
                    end
                end
            end
            PERMUTE: begin
                for (int i = 0; i < VECTOR_LANES; i++) begin
                    idx = perm[i*IDX_W +: IDX_W];
                    if (int'(idx) < VECTOR_LANES) begin
                        out_l[i] = in_l[idx];
                    end
                end
            end
            PASS: begin
                for (int i = 0; i < VECTOR_LANES; i++) begin
                    out_l[i] = in_l[i];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < VECTOR_LANES; i++) begin
            next_vec[i*DATA_WIDTH +: DATA_WIDTH] = out_l[i];
        end
    end

endmodule

// File: rtl/vector_permute_unit.sv
// Handshaked vector permute stage: one registered output slot in front of
// the lane crossbar, plus the programmable lane-permute table.
module vector_permute_unit
    import vector_permute_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int VECTOR_LANES = 16,
    parameter int MAT_DIM      = 3,
    localparam int IDX_W       = $clog2(VECTOR_LANES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [2:0]                         funct,
    input  logic [IDX_W-1:0]                   lane_sel,
    input  logic [VECTOR_LANES*DATA_WIDTH-1:0] vec_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [VECTOR_LANES*DATA_WIDTH-1:0] vec_out
);

    if (!params_ok(VECTOR_LANES, MAT_DIM, DATA_WIDTH)) begin : g_bad_params
        $error("vector_permute_unit: VECTOR_LANES must be >= 9 and >= MAT_DIM*MAT_DIM");
    end

    logic [IDX_W-1:0]                   perm [VECTOR_LANES];
    logic [VECTOR_LANES*IDX_W-1:0]      perm_flat;
    logic [VECTOR_LANES*DATA_WIDTH-1:0] next_vec;
    logic                               accept;

    // valid/ready: a transfer happens on any edge where valid && ready; the
    // output slot frees itself when the consumer takes it, so a new op can be
    // accepted in the same cycle and continuous flow runs without bubbles.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        for (int i = 0; i < VECTOR_LANES; i++) begin
            perm_flat[i*IDX_W +: IDX_W] = perm[i];
        end
    end

    vector_permute_xbar #(
        .DATA_WIDTH  (DATA_WIDTH),
        .VECTOR_LANES(VECTOR_LANES),
        .MAT_DIM     (MAT_DIM)
    ) u_xbar (
        .funct   (funct),
        .lane_sel(lane_sel),
        .vec_in  (vec_in),
        .perm    (perm_flat),
        .next_vec(next_vec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            vec_out   <= '0;
            for (int i = 0; i < VECTOR_LANES; i++) begin
                perm[i] <= IDX_W'(i);
            end
        end else if (accept) begin
            // LOAD_PERM only rewrites the table; it leaves the last result in vec_out.
            if (funct_e'(funct) == LOAD_PERM) begin
                out_valid <= 1'b0;
                for (int i = 0; i < VECTOR_LANES; i++) begin
                    perm[i] <= vec_in[i*DATA_WIDTH +: IDX_W];
                end
            end else begin
                out_valid <= 1'b1;
                vec_out   <= next_vec;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/vector_permute_unit.md
Name: vector_permute_unit

Overview:
- Parametrised, handshaked successor to the fixed 3x3 skew/transpose permute stage in the vector datapath.
- Sits between the vector register file read port and the vector FPU lanes.
- Generalises transpose to MAT_DIM x MAT_DIM and adds negate, broadcast, passthrough and a programmable lane-permute table.
- Uses a valid/ready handshake with a single registered output stage.

Parameters:
- DATA_WIDTH, 32, lane width in bits; the sign bit is bit DATA_WIDTH-1 (IEEE float).
- VECTOR_LANES, 16, number of lanes; must be at least 9 and at least MAT_DIM*MAT_DIM.
- MAT_DIM, 3, square matrix dimension for TRANSPOSE; matrices are row-major in lanes 0..MAT_DIM*MAT_DIM-1.
- IDX_W, $clog2(VECTOR_LANES), lane index width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input op valid.
- in_ready  out  1  unit can accept an op this cycle.
- funct  in  3  op select; encoding in Behaviour.
- lane_sel  in  IDX_W  source lane for BROADCAST.
- vec_in  in  VECTOR_LANES*DATA_WIDTH  packed lanes, lane i at [i].
- out_valid  out  1  vec_out holds a result.
- out_ready  in  1  consumer accepts vec_out.
- vec_out  out  VECTOR_LANES*DATA_WIDTH  registered result.

Behaviour:
- Reset (asynchronous, rst_n low):
  - out_valid=0 and vec_out=0.
  - Permute table perm[i]=i for every lane (identity).
  - Any op held in the output register is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no bubble under continuous flow).
  - An op is accepted when in_valid && in_ready.
  - Latency is 1 cycle: the result is in vec_out with out_valid=1 on the next edge.
  - While out_valid && !out_ready, vec_out and out_valid hold stable and in_ready=0.
  - If no op is accepted and out_ready=1, out_valid falls to 0; vec_out keeps its last value.
- Funct encoding (neg(x) = x with bit DATA_WIDTH-1 inverted):
  - 000 SKEW: lanes 0..8 = [0, v2, -v1, -v2, 0, v0, v1, -v0, 0], where v = vec_in and -x = neg(x). Lanes 9 and above = 0.
  - 001 TRANSPOSE: out[MAT_DIM*i+j] = in[MAT_DIM*j+i] for i,j < MAT_DIM. Lanes at or above MAT_DIM*MAT_DIM = 0.
  - 010 NEGATE: out[i] = neg(in[i]) for all lanes.
  - 011 BROADCAST: out[i] = in[lane_sel] for all lanes. If lane_sel >= VECTOR_LANES, all lanes = 0.
  - 100 PERMUTE: out[i] = in[perm[i]]. An entry >= VECTOR_LANES gives 0 in that lane.
  - 101 LOAD_PERM: perm[i] <= vec_in[i][IDX_W-1:0] on accept. Produces no result: out_valid <= 0 on that edge, vec_out unchanged.
  - 110 PASS: out = in.
  - 111 reserved: out = 0 with out_valid=1.
- Ordering:
  - Ops take effect in accept order.
  - A PERMUTE accepted the cycle after a LOAD_PERM uses the new table.
  - The table write and the out_valid clear happen on the same edge.
- Back-pressure on LOAD_PERM:
  - LOAD_PERM needs in_ready like any other op.
  - It is never accepted while a result is stalled, so no result is lost.
- Zero values are all-zero bits (+0.0); negating 0 is not special-cased.
- Reset asserted mid-stall drops the pending result; the consumer sees out_valid fall asynchronously.

Decomposition:
- vector_permute_pkg holds:
  - funct_e enum: SKEW, TRANSPOSE, NEGATE, BROADCAST, PERMUTE, LOAD_PERM, PASS, RSVD.
  - The neg helper function.
  - Elaboration assertions on VECTOR_LANES >= 9 and MAT_DIM*MAT_DIM <= VECTOR_LANES.
- One sub-module, vector_permute_xbar: purely combinational. It takes vec_in, funct, lane_sel and perm, and produces next_vec.
- The top level holds the handshake, output register and perm table.

Test Plan:
- After reset, check vec_out=0 and out_valid=0. Send PASS with lane i = i, and out_ready=1 → the next cycle gives vec_out lane i = i with out_valid=1, and in_ready stays 1 throughout.
- SKEW with v0=1.0 (32'h3F800000), v1=2.0 (32'h40000000), v2=3.0 (32'h40400000) → lanes 0..8 = 0, 40400000, C0000000, C0400000, 0, 3F800000, 40000000, BF800000, 0, and lanes 9-15 = 0. Repeat with MAT_DIM=4 TRANSPOSE on lanes 0..15 = 0..15 → lane 4i+j = 4j+i.
- LOAD_PERM with lane i = 15-i, then PERMUTE back-to-back with lane i = 100+i → out_valid stays 0 for the LOAD_PERM cycle, then vec_out lane i = 115-i. Then reset, PERMUTE again → identity output.
- Hold out_ready=0 for 3 cycles after a BROADCAST with lane_sel=5 → vec_out stays at all lanes = in[5], in_ready=0 and a pending NEGATE is not accepted. Release out_ready → NEGATE result appears on the next cycle.
- Continuous in_valid=1 and out_ready=1 for 16 PASS ops → 16 results in consecutive cycles, in order. Assert rst_n low mid-stream with out_ready=0 → out_valid=0 immediately, with no clock edge needed.
